// File: rtl/hd_memory_arbiter.sv
// hd_memory_arbiter
// Purpose: single-port access arbiter in front of the latch-based HD memory.
//   It arbitrates between encoder row writes, host word reads/writes and
//   AM-search commands, and sequences the memory's search handshake.
// Optional feature macro: HD_MEM_ARB_PERF_EN adds 32-bit saturating
//   grant/busy counters (perf_*_o) cleared by perf_clr_i.
// Port summary:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   test_en_i         clock-gate test enable (consumed on the memory side)
//   enc_*             encoder row-write request/grant
//   host_*            host word access request/grant and registered read data
//   srch_*            AM-search command (level request) and held result
//   busy_o            search sequence in progress (START..RELEASE)
//   mem_*             interface to hd_memory
//   dbg_state_o       current FSM state (0 IDLE, 1 START, 2 SEARCH, 3 RELEASE)
// Handshake: a request is a level held by the requester; a grant is a
//   single-cycle acknowledge in which the access is issued to the memory.
//   A host read returns host_rvalid_o/host_rdata_o exactly one cycle later.
//   srch_req_i is held until srch_done_o, and must be seen low once before
//   another search is accepted.
module hd_memory_arbiter #(
  parameter int ROW_ADDR_W  = 6,
  parameter int WORD_ADDR_W = 3,
  parameter int WORD_W      = 32,
  parameter int ROW_W       = 256,
  parameter int IDX_W       = 5,
  parameter int DIST_W      = 9
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              test_en_i,
  input  logic                              enc_req_i,
  input  logic [ROW_ADDR_W-1:0]             enc_addr_i,
  input  logic [ROW_W-1:0]                  enc_row_i,
  output logic                              enc_gnt_o,
  input  logic                              host_req_i,
  input  logic                              host_we_i,
  input  logic [ROW_ADDR_W+WORD_ADDR_W-1:0] host_addr_i,
  input  logic [WORD_W-1:0]                 host_wdata_i,
  output logic                              host_gnt_o,
  output logic                              host_rvalid_o,
  output logic [WORD_W-1:0]                 host_rdata_o,
  input  logic                              srch_req_i,
  input  logic [IDX_W-1:0]                  srch_end_idx_i,
  output logic                              srch_done_o,
  output logic [IDX_W-1:0]                  srch_idx_o,
  output logic [DIST_W-1:0]                 srch_dist_o,
  output logic                              busy_o,
  output logic                              mem_we_o,
  output logic                              mem_word_mode_o,
  output logic [ROW_ADDR_W+WORD_ADDR_W-1:0] mem_raddr_o,
  output logic [ROW_ADDR_W+WORD_ADDR_W-1:0] mem_waddr_o,
  output logic [ROW_W-1:0]                  mem_row_o,
  output logic [WORD_W-1:0]                 mem_word_o,
  input  logic [WORD_W-1:0]                 mem_word_i,
  output logic                              mem_srch_start_o,
  output logic                              mem_srch_stall_o,
  output logic [IDX_W-1:0]                  mem_srch_end_idx_o,
  input  logic                              mem_srch_valid_i,
  input  logic                              mem_srch_is_min_i,
  input  logic [IDX_W-1:0]                  mem_srch_idx_i,
  input  logic [DIST_W-1:0]                 mem_srch_dist_i,
`ifdef HD_MEM_ARB_PERF_EN
  input  logic                              perf_clr_i,
  output logic [31:0]                       perf_enc_o,
  output logic [31:0]                       perf_host_o,
  output logic [31:0]                       perf_srch_o,
`endif
  output logic [1:0]                        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_SEARCH  = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                rr_host_q, rr_host_d;   // 1: host wins a tie
  logic                armed_q, armed_d;       // srch_req_i seen low since done
  logic                rvalid_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                done_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DIST_W-1:0]   dist_q;
  logic [IDX_W-1:0]    end_idx_q;

  logic go_start, srch_hit, enc_win, host_win;

  // test_en_i only matters to the memory's own clock gates.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  assign go_start = (state_q == S_IDLE) && srch_req_i && armed_q;
  assign srch_hit = mem_srch_valid_i && mem_srch_is_min_i;

  // Grants only in IDLE, and never in the cycle a search is accepted.
  always_comb begin
    enc_win  = 1'b0;
    host_win = 1'b0;
    if (state_q == S_IDLE && !go_start) begin
      enc_win  = enc_req_i && (!host_req_i || !rr_host_q);
      host_win = host_req_i && !enc_win;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (go_start) state_d = S_START;
      S_START:   state_d = S_SEARCH;
      S_SEARCH:  if (srch_hit) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    enc_gnt_o        = enc_win;
    host_gnt_o       = host_win;
    mem_we_o         = enc_win || (host_win && host_we_i);
    mem_word_mode_o  = host_win;
    mem_waddr_o      = enc_win ? {enc_addr_i, {WORD_ADDR_W{1'b0}}} : host_addr_i;
    mem_raddr_o      = host_addr_i;
    mem_row_o        = enc_row_i;
    mem_word_o       = host_wdata_i;
    // Start drops in RELEASE so the memory sees a falling edge and re-idles.
    mem_srch_start_o = (state_q == S_START) || (state_q == S_SEARCH);
    busy_o           = (state_q != S_IDLE);
  end

  assign mem_srch_stall_o   = 1'b0;
  assign mem_srch_end_idx_o = end_idx_q;
  assign host_rvalid_o      = rvalid_q;
  assign host_rdata_o       = rdata_q;
  assign srch_done_o        = done_q;
  assign srch_idx_o         = idx_q;
  assign srch_dist_o        = dist_q;
  assign dbg_state_o        = state_q;

  always_comb begin
    rr_host_d = rr_host_q;
    if (enc_win)  rr_host_d = 1'b1;
    if (host_win) rr_host_d = 1'b0;
    armed_d = armed_q;
    if (state_q == S_SEARCH && srch_hit) armed_d = 1'b0;
    else if (!srch_req_i)                armed_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_host_q <= 1'b0;
      armed_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      dist_q    <= '1;
      end_idx_q <= '0;
    end else begin
      rr_host_q <= rr_host_d;
      armed_q   <= armed_d;
      // Memory read is combinational on mem_raddr_o; register it at grant.
      rvalid_q  <= host_win && !host_we_i;
      if (host_win && !host_we_i) rdata_q <= mem_word_i;
      // Done is registered so it lines up with the captured result.
      done_q    <= (state_q == S_SEARCH) && srch_hit;
      if (state_q == S_SEARCH && srch_hit) begin
        idx_q  <= mem_srch_idx_i;
        dist_q <= mem_srch_dist_i;
      end
      if (go_start) end_idx_q <= srch_end_idx_i;
    end
  end

`ifdef HD_MEM_ARB_PERF_EN
  logic [31:0] perf_enc_q, perf_host_q, perf_srch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_enc_q  <= '0;
      perf_host_q <= '0;
      perf_srch_q <= '0;
    end else if (perf_clr_i) begin
      perf_enc_q  <= '0;
      perf_host_q <= '0;
      perf_srch_q <= '0;
    end else begin
      if (enc_win && perf_enc_q != '1)   perf_enc_q  <= perf_enc_q + 32'd1;
      if (host_win && perf_host_q != '1) perf_host_q <= perf_host_q + 32'd1;
      if (busy_o && perf_srch_q != '1)   perf_srch_q <= perf_srch_q + 32'd1;
    end
  end

  assign perf_enc_o  = perf_enc_q;
  assign perf_host_o = perf_host_q;
  assign perf_srch_o = perf_srch_q;
`endif

endmodule

// File: tb/tb_hd_memory_arbiter.sv
// tb_hd_memory_arbiter
// Purpose: self-checking bench for hd_memory_arbiter with a behavioural
//   word/row memory and a simple AM-search responder. Host read results are
//   checked through an expected-data queue filled when a read is driven.
module tb_hd_memory_arbiter;

  localparam int AW = 9;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          test_en_i;
  logic          enc_req_i;
  logic [5:0]    enc_addr_i;
  logic [255:0]  enc_row_i;
  logic          enc_gnt_o;
  logic          host_req_i;
  logic          host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [31:0]   host_wdata_i;
  logic          host_gnt_o;
  logic          host_rvalid_o;
  logic [31:0]   host_rdata_o;
  logic          srch_req_i;
  logic [4:0]    srch_end_idx_i;
  logic          srch_done_o;
  logic [4:0]    srch_idx_o;
  logic [8:0]    srch_dist_o;
  logic          busy_o;
  logic          mem_we_o;
  logic          mem_word_mode_o;
  logic [AW-1:0] mem_raddr_o;
  logic [AW-1:0] mem_waddr_o;
  logic [255:0]  mem_row_o;
  logic [31:0]   mem_word_o;
  logic [31:0]   mem_word_i;
  logic          mem_srch_start_o;
  logic          mem_srch_stall_o;
  logic [4:0]    mem_srch_end_idx_o;
  logic          mem_srch_valid_i;
  logic          mem_srch_is_min_i;
  logic [4:0]    mem_srch_idx_i;
  logic [8:0]    mem_srch_dist_i;
  logic [1:0]    dbg_state_o;
`ifdef HD_MEM_ARB_PERF_EN
  logic          perf_clr_i = 1'b0;
  logic [31:0]   perf_enc_o, perf_host_o, perf_srch_o;
`endif

  hd_memory_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_en_i(test_en_i),
    .enc_req_i(enc_req_i), .enc_addr_i(enc_addr_i), .enc_row_i(enc_row_i),
    .enc_gnt_o(enc_gnt_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .srch_req_i(srch_req_i), .srch_end_idx_i(srch_end_idx_i),
    .srch_done_o(srch_done_o), .srch_idx_o(srch_idx_o), .srch_dist_o(srch_dist_o),
    .busy_o(busy_o),
    .mem_we_o(mem_we_o), .mem_word_mode_o(mem_word_mode_o),
    .mem_raddr_o(mem_raddr_o), .mem_waddr_o(mem_waddr_o),
    .mem_row_o(mem_row_o), .mem_word_o(mem_word_o), .mem_word_i(mem_word_i),
    .mem_srch_start_o(mem_srch_start_o), .mem_srch_stall_o(mem_srch_stall_o),
    .mem_srch_end_idx_o(mem_srch_end_idx_o),
    .mem_srch_valid_i(mem_srch_valid_i), .mem_srch_is_min_i(mem_srch_is_min_i),
    .mem_srch_idx_i(mem_srch_idx_i), .mem_srch_dist_i(mem_srch_dist_i),
`ifdef HD_MEM_ARB_PERF_EN
    .perf_clr_i(perf_clr_i), .perf_enc_o(perf_enc_o),
    .perf_host_o(perf_host_o), .perf_srch_o(perf_srch_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- memory model ----------------
  logic [31:0] mem [512];
  logic [3:0]  srch_cnt;
  logic [4:0]  m_idx;
  logic [8:0]  m_dist;

  assign mem_word_i = mem[mem_raddr_o];

  always @(posedge clk_i) begin
    if (mem_we_o) begin
      if (mem_word_mode_o) mem[mem_waddr_o] <= mem_word_o;
      else for (int w = 0; w < 8; w++)
        mem[int'(mem_waddr_o[8:3]) * 8 + w] <= mem_row_o[w*32 +: 32];
    end
  end

  // Search responder: reports the final minimum a few cycles after start.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                srch_cnt <= '0;
    else if (!mem_srch_start_o) srch_cnt <= '0;
    else if (srch_cnt != 4'hF)  srch_cnt <= srch_cnt + 4'd1;
  end
  assign mem_srch_valid_i  = mem_srch_start_o && (srch_cnt >= 4'd3);
  assign mem_srch_is_min_i = mem_srch_valid_i;
  assign mem_srch_idx_i    = m_idx;
  assign mem_srch_dist_i   = m_dist;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && srch_done_o) done_cnt++;
    if (rst_ni && host_rvalid_o) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
      else                   chk("host_rdata", host_rdata_o, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      enc_req_i = 0; host_req_i = 0; host_we_i = 0;
      @(negedge clk_i);
    end
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [31:0] data);
    @(posedge clk_i); #1;
    enc_req_i = 0; host_req_i = 1; host_we_i = we;
    host_addr_i = addr; host_wdata_i = data;
    if (!we) exp_q.push_back(data);
    @(negedge clk_i);
    chk("host_gnt", host_gnt_o, 1);
    chk("host_we", mem_we_o, we);
    if (we) begin
      chk("host_word_mode", mem_word_mode_o, 1);
      chk("host_waddr", mem_waddr_o, addr);
    end
  endtask

  task automatic run_search(input logic [4:0] e, input logic [4:0] ri,
                            input logic [8:0] rd, input logic [255:0] row);
    bit got;
    m_idx = ri; m_dist = rd;
    @(posedge clk_i); #1;
    srch_req_i = 1; srch_end_idx_i = e;
    @(negedge clk_i);
    chk("srch_accept_nogrant", {enc_gnt_o, host_gnt_o}, 0);
    @(posedge clk_i); #1;
    enc_req_i = 1; enc_addr_i = 6'd9; enc_row_i = row; srch_end_idx_i = ~e;
    @(negedge clk_i);
    chk("start_state", dbg_state_o, 1);
    chk("start_asserted", mem_srch_start_o, 1);
    chk("start_busy", busy_o, 1);
    chk("start_end_idx", mem_srch_end_idx_o, e);
    chk("start_we_blocked", mem_we_o, 0);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if (srch_done_o) got = 1;
      else begin
        chk("srch_we_blocked", mem_we_o, 0);
        chk("srch_enc_blocked", enc_gnt_o, 0);
        chk("srch_start_held", mem_srch_start_o, 1);
      end
    end
    chk("srch_done_seen", got, 1);
    chk("rel_idx", srch_idx_o, ri);
    chk("rel_dist", srch_dist_o, rd);
    chk("rel_start_drop", mem_srch_start_o, 0);
    chk("rel_busy", busy_o, 1);
    chk("rel_we_blocked", mem_we_o, 0);
    // srch_req_i still high here: must not retrigger.
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("post_enc_gnt", enc_gnt_o, 1);
    chk("post_enc_we", mem_we_o, 1);
    chk("post_enc_mode", mem_word_mode_o, 0);
    chk("post_enc_waddr", mem_waddr_o, {6'd9, 3'd0});
    chk("post_busy", busy_o, 0);
    @(posedge clk_i); #1;
    enc_req_i = 0;
    @(negedge clk_i);
    chk("no_rearm_busy", busy_o, 0);
    chk("no_rearm_start", mem_srch_start_o, 0);
    @(posedge clk_i); #1;
    srch_req_i = 0;
    @(negedge clk_i);
    host_op(0, {6'd9, 3'd7}, row[255:224]);
    idle(2);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0]  a_word, b_word;
  logic [255:0] row1, row2, row3;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) begin
      row1[i*32 +: 32] = $urandom;
      row2[i*32 +: 32] = $urandom;
      row3[i*32 +: 32] = $urandom;
    end
    a_word = $urandom; b_word = $urandom;
    m_idx = 0; m_dist = 0;
    rst_ni = 0; test_en_i = 0;
    enc_req_i = 0; enc_addr_i = 0; enc_row_i = '0;
    host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0;
    srch_req_i = 0; srch_end_idx_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("rst_grants", {enc_gnt_o, host_gnt_o, host_rvalid_o, srch_done_o}, 0);
      chk("rst_dist", srch_dist_o, 9'h1FF);
      chk("rst_idx", srch_idx_o, 0);
      chk("rst_we", mem_we_o, 0);
      chk("rst_start_stall", {mem_srch_start_o, mem_srch_stall_o, busy_o}, 0);
      chk("rst_state", dbg_state_o, 0);
    end

    // Prefill, then back-to-back reads.
    host_op(1, {6'd1, 3'd0}, a_word);
    host_op(1, {6'd1, 3'd1}, b_word);
    host_op(0, {6'd1, 3'd0}, a_word);
    host_op(0, {6'd1, 3'd1}, b_word);
    idle(2);

    // Round-robin: encoder and host read requesting together.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      enc_req_i = 1; enc_addr_i = 6'd2; enc_row_i = row1;
      host_req_i = 1; host_we_i = 0; host_addr_i = {6'd1, 3'd0};
      if (k % 2 == 1) exp_q.push_back(a_word);
      @(negedge clk_i);
      chk("rr_enc_gnt", enc_gnt_o, (k % 2 == 0));
      chk("rr_host_gnt", host_gnt_o, (k % 2 == 1));
      chk("rr_rvalid", host_rvalid_o, (k == 2));
      if (k == 0) begin
        chk("enc_we", mem_we_o, 1);
        chk("enc_mode", mem_word_mode_o, 0);
        chk("enc_waddr", mem_waddr_o, {6'd2, 3'd0});
      end
    end
    idle(1);
    chk("rr_rvalid_last", host_rvalid_o, 1);
    host_op(0, {6'd2, 3'd3}, row1[127:96]);
    idle(1);

    // Word write then read of the same address.
    host_op(1, {6'd3, 3'd5}, 32'hDEADBEEF);
    host_op(0, {6'd3, 3'd5}, 32'hDEADBEEF);
    idle(2);

    // Search with end index 4, result idx 2 / dist 37.
    run_search(5'd4, 5'd2, 9'd37, row2);
    chk("done_once", done_cnt, 1);

    // Reset in the middle of a search.
    m_idx = 5'd1; m_dist = 9'd2;
    @(posedge clk_i); #1;
    srch_req_i = 1; srch_end_idx_i = 5'd3;
    @(posedge clk_i);
    @(posedge clk_i); #2;
    rst_ni = 0;
    #1;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_start", mem_srch_start_o, 0);
    chk("mrst_idx", srch_idx_o, 0);
    chk("mrst_dist", srch_dist_o, 9'h1FF);
    chk("mrst_state", dbg_state_o, 0);
    srch_req_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    idle(10);
    chk("mrst_no_done", done_cnt, 1);

    // Single-vector search.
    run_search(5'd0, 5'd0, 9'd5, row3);
    chk("done_total", done_cnt, 2);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
